// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter command scheduler.
// Optional feature macro: CNT_SCHED_STOP_ON_WRAP_EN (used by counter_cmd_scheduler).
package counter_sched_pkg;

    // Command op codes as seen on req_op.
    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_READ = 2'd3
    } op_e;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCount,
        StResp
    } state_e;

    // Counter control levels while no command is driving it.
    localparam logic IdleUp      = 1'b0;
    localparam logic IdleSetB    = 1'b1;
    localparam logic IdleEnableB = 1'b1;

    // True for ops that step the counter.
    function automatic logic is_count_op(input op_e op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or after ptr_i,
// wrapping, and reports the pointer to use after that grant. The pointer register lives
// in the parent.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] next_ptr_o
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    // Scan requesters in priority order starting at the pointer.
    always_comb begin
        logic found;
        int unsigned idx;
        grant_o    = '0;
        next_ptr_o = ptr_i;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr_i) + off) % NUM_REQ;
            if (!found && valid_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                next_ptr_o   = IdW'((idx + 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/counter_cmd_scheduler.sv
// Shares one external up/down counter between NUM_REQ requesters. Each accepted command
// (LOAD / UP k / DOWN k / READ) drives the counter pins for its duration, then a one-cycle
// response reports the final count and whether the counter wrapped.
// Optional feature macro: CNT_SCHED_STOP_ON_WRAP_EN -- when defined, a count command ends
// after the step that wraps the counter instead of running all k steps.
module counter_cmd_scheduler
    import counter_sched_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned STEP_W  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [STEP_W*NUM_REQ-1:0]  req_data,
    output logic                       cnt_up,
    output logic                       cnt_set_b,
    output logic                       cnt_enable_b,
    output logic [N-1:0]               cnt_set,
    input  logic                       cnt_carry_b,
    input  logic [N-1:0]               cnt_q,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [N-1:0]               rsp_q,
    output logic                       rsp_wrapped
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic [IdW-1:0]      id_q, id_d;
    logic                wrap_q, wrap_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IdW-1:0]      next_ptr;
    logic [IdW-1:0]      gid;
    logic [1:0]          op_raw;
    logic [STEP_W-1:0]   data_sel;
    logic                count_done;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .valid_i   (req_valid),
        .ptr_i     (ptr_q),
        .grant_o   (grant),
        .next_ptr_o(next_ptr)
    );

    // Encode the one-hot grant and mux out that requester's op and data.
    always_comb begin
        gid      = '0;
        op_raw   = '0;
        data_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gid      = IdW'(i);
                op_raw   = req_op[2*i +: 2];
                data_sel = req_data[STEP_W*i +: STEP_W];
            end
        end
    end

    // Last count step: step counter expires, or (optionally) the counter wraps this cycle.
    always_comb begin
`ifdef CNT_SCHED_STOP_ON_WRAP_EN
        count_done = (step_q == STEP_W'(1)) || !cnt_carry_b;
`else
        count_done = (step_q == STEP_W'(1));
`endif
    end

    // Next-state logic and all outputs, decoded from the current state.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        step_d       = step_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        wrap_d       = wrap_q;
        req_ready    = '0;
        cnt_up       = IdleUp;
        cnt_set_b    = IdleSetB;
        cnt_enable_b = IdleEnableB;
        cnt_set      = '0;
        rsp_valid    = 1'b0;
        rsp_id       = '0;
        rsp_q        = '0;
        rsp_wrapped  = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = grant;
                if (|grant) begin
                    op_d   = op_e'(op_raw);
                    step_d = data_sel;
                    id_d   = gid;
                    ptr_d  = next_ptr;
                    wrap_d = 1'b0;
                    if (op_e'(op_raw) == OP_LOAD) begin
                        state_d = StLoad;
                    end else if (is_count_op(op_e'(op_raw)) && (data_sel != '0)) begin
                        state_d = StCount;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StLoad: begin
                cnt_enable_b = 1'b0;
                cnt_set_b    = 1'b0;
                cnt_set      = step_q[N-1:0];
                state_d      = StResp;
            end
            StCount: begin
                cnt_enable_b = 1'b0;
                cnt_up       = (op_q == OP_UP);
                step_d       = step_q - STEP_W'(1);
                // The edge closing this cycle wraps the counter.
                if (!cnt_carry_b) begin
                    wrap_d = 1'b1;
                end
                if (count_done) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid   = 1'b1;
                rsp_id      = id_q;
                rsp_q       = cnt_q;
                rsp_wrapped = wrap_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset drops any in-flight command.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OP_LOAD;
            step_q  <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule

// File: tb/tb_counter_cmd_scheduler.sv
// Self-checking bench for counter_cmd_scheduler with a behavioural 4-bit up/down counter
// attached. Directed table, arbitration and reset sequences, then random commands checked
// against an arithmetic model of each command's effect.
module tb_counter_cmd_scheduler;

    localparam int OpLoad = 0;
    localparam int OpUp   = 1;
    localparam int OpDown = 2;
    localparam int OpRead = 3;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_data;
    logic        cnt_up;
    logic        cnt_set_b;
    logic        cnt_enable_b;
    logic [3:0]  cnt_set;
    logic        cnt_carry_b;
    logic [3:0]  cnt_q;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [3:0]  rsp_q;
    logic        rsp_wrapped;

    int vectors;
    int miscompares;
    int model_q;
    int model_ptr;

    typedef struct {
        int id;
        int op;
        int data;
        int exp_q;
        int exp_wr;
        int exp_lat;
        int exp_en;
    } vec_t;

    vec_t tab[8];

    counter_cmd_scheduler #(
        .N(4),
        .NUM_REQ(2),
        .STEP_W(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .cnt_up      (cnt_up),
        .cnt_set_b   (cnt_set_b),
        .cnt_enable_b(cnt_enable_b),
        .cnt_set     (cnt_set),
        .cnt_carry_b (cnt_carry_b),
        .cnt_q       (cnt_q),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_q       (rsp_q),
        .rsp_wrapped (rsp_wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Attached counter: load or step when enabled; carry_b low at the wrap point.
    initial cnt_q = 4'd0;
    always @(posedge clock) begin
        if (!cnt_enable_b) begin
            if (!cnt_set_b) cnt_q <= cnt_set;
            else if (cnt_up) cnt_q <= cnt_q + 4'd1;
            else cnt_q <= cnt_q - 4'd1;
        end
    end
    assign cnt_carry_b = cnt_up ? (cnt_q != 4'hF) : (cnt_q != 4'h0);

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // At most one ready bit, whenever any is raised.
    always @(negedge clock) begin
        #1;
        if (req_ready != 2'b00) check("ready onehot", $countones(req_ready), 1);
    end

    // Effect of one command from count q: final count, wrap flag, cycles to response,
    // cycles with the counter enabled.
    task automatic model(input int op, input int data, input int q,
                         output int nq, output int wr, output int lat, output int en);
        int steps;
        nq = q; wr = 0; lat = 1; en = 0;
        if (op == OpLoad) begin
            nq = data % 16; lat = 2; en = 1;
        end else if ((op == OpUp || op == OpDown) && data != 0) begin
            steps = data;
            if (op == OpUp) wr = (data > 15 - q) ? 1 : 0;
            else wr = (data > q) ? 1 : 0;
`ifdef CNT_SCHED_STOP_ON_WRAP_EN
            if (wr != 0) steps = (op == OpUp) ? 16 - q : q + 1;
`endif
            nq = (op == OpUp) ? (q + steps) % 16 : (((q - steps) % 16) + 16) % 16;
            lat = steps + 1;
            en = steps;
        end
    endtask

    task automatic run_cmd(input string name, input int id, input int op, input int data,
                           input int exp_q, input int exp_wr, input int exp_lat,
                           input int exp_en);
        int  waited;
        int  lat;
        int  en_cnt;
        bit  got;
        @(negedge clock);
        req_valid = 2'b00;
        req_valid[id] = 1'b1;
        req_op[2*id +: 2] = 2'(op);
        req_data[8*id +: 8] = 8'(data);
        #1;
        waited = 0;
        while (!req_ready[id] && waited < 50) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check({name, " ready"}, int'(req_ready), 1 << id);
        if (!req_ready[id]) begin
            req_valid = 2'b00;
            return;
        end
        lat = 0; en_cnt = 0; got = 0;
        while (!got && lat < 300) begin
            @(negedge clock);
            req_valid = 2'b00;
            #1;
            lat++;
            if (!cnt_enable_b) en_cnt++;
            if (op == OpLoad && lat == 1)
                check({name, " set"}, int'({cnt_set_b, cnt_set}), int'({1'b0, 4'(data)}));
            if (rsp_valid) got = 1;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " rsp_id"}, int'(rsp_id), id);
        check({name, " rsp_q"}, int'(rsp_q), exp_q);
        check({name, " rsp_wrapped"}, int'(rsp_wrapped), exp_wr);
        check({name, " enable cycles"}, en_cnt, exp_en);
        model_q = exp_q;
        model_ptr = (id + 1) % 2;
    endtask

    // Both requesters hold READ: grants alternate from model_ptr, one accept every 2 cycles.
    task automatic arb_seq(input string name);
        int exp_id;
        @(negedge clock);
        req_valid = 2'b11;
        req_op = 4'hF;
        #1;
        exp_id = model_ptr;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clock);
                #1;
            end
            if (c % 2 == 0) begin
                check({name, " grant"}, int'(req_ready), 1 << exp_id);
            end else begin
                check({name, " rsp_valid"}, int'(rsp_valid), 1);
                check({name, " rsp_id"}, int'(rsp_id), exp_id);
                check({name, " rsp_q"}, int'(rsp_q), model_q);
                exp_id = 1 - exp_id;
            end
        end
        @(negedge clock);
        req_valid = 2'b00;
        model_ptr = exp_id;
    endtask

    initial begin
        int nq, wr, lat, en, id, op, data;
        vectors = 0; miscompares = 0; model_q = 0; model_ptr = 0;
        reset = 1'b1; req_valid = '0; req_op = '0; req_data = '0;

        tab[0] = '{0, OpLoad, 'hA, 'hA, 0, 2, 1};
        tab[1] = '{0, OpLoad, 'hE, 'hE, 0, 2, 1};
`ifdef CNT_SCHED_STOP_ON_WRAP_EN
        tab[2] = '{1, OpUp, 3, 'h0, 1, 3, 2};
`else
        tab[2] = '{1, OpUp, 3, 'h1, 1, 4, 3};
`endif
        tab[3] = '{0, OpLoad, 'h1, 'h1, 0, 2, 1};
        tab[4] = '{1, OpDown, 2, 'hF, 1, 3, 2};
        tab[5] = '{0, OpDown, 0, 'hF, 0, 1, 0};
        tab[6] = '{1, OpRead, 'h55, 'hF, 0, 1, 0};
`ifdef CNT_SCHED_STOP_ON_WRAP_EN
        tab[7] = '{0, OpUp, 'h10, 'h0, 1, 2, 1};
`else
        tab[7] = '{0, OpUp, 'h10, 'hF, 1, 17, 16};
`endif

        repeat (2) @(negedge clock);
        #1;
        check("reset enable_b", int'(cnt_enable_b), 1);
        check("reset set_b", int'(cnt_set_b), 1);
        check("reset up", int'(cnt_up), 0);
        check("reset set", int'(cnt_set), 0);
        check("reset rsp", int'({rsp_valid, rsp_id, rsp_q, rsp_wrapped}), 0);
        check("reset ready", int'(req_ready), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_cmd($sformatf("tab%0d", i), tab[i].id, tab[i].op, tab[i].data,
                    tab[i].exp_q, tab[i].exp_wr, tab[i].exp_lat, tab[i].exp_en);

        arb_seq("arb");

        // Reset during the 4th step of UP 10; pointer is 1 beforehand.
        run_cmd("rst load", 1, OpLoad, 0, 0, 0, 2, 1);
        run_cmd("rst pre", 0, OpRead, 0, 0, 0, 1, 0);
        @(negedge clock);
        req_valid = 2'b01;
        req_op[1:0] = 2'(OpUp);
        req_data[7:0] = 8'd10;
        #1;
        check("rst accept", int'(req_ready), 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            req_valid = 2'b00;
            #1;
            check($sformatf("rst step%0d", c), int'(cnt_enable_b), 0);
        end
        reset = 1'b1;
        #1;
        check("rst enable_b", int'(cnt_enable_b), 1);
        check("rst set_b", int'(cnt_set_b), 1);
        check("rst up", int'(cnt_up), 0);
        check("rst rsp_valid", int'(rsp_valid), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst q held", int'(cnt_q), 3);
        check("rst no rsp", int'(rsp_valid), 0);
        model_q = 3;
        model_ptr = 0;
        arb_seq("post-rst arb");

        for (int i = 0; i < 40; i++) begin
            id = int'($urandom % 2);
            op = int'($urandom % 4);
            data = ($urandom % 4 == 0) ? int'($urandom % 256) : int'($urandom % 20);
            model(op, data, model_q, nq, wr, lat, en);
            run_cmd($sformatf("rnd%0d op%0d d%0d", i, op, data), id, op, data, nq, wr, lat, en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
